// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - 4-digit seven-segment scan controller with frame-synchronous double buffer
module seven_seg_scan_ctrl #(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic [3:0]  wr_dp,
  input  logic [3:0]  digit_en,
  input  logic        lz_blank,
  output logic [3:0]  hex,
  output logic        dp_n,
  output logic [3:0]  an,
  output logic        frame_tick,
  output logic        pending
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] SLOT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  typedef enum logic {BLANK, SHOW} phase_t;
  localparam phase_t START_PH = (BLANK_CYC == 0) ? SHOW : BLANK;

  phase_t        phase, nxt_phase;
  logic [1:0]    idx, nxt_idx;
  logic [CW-1:0] cnt, nxt_cnt;
  logic [15:0]   active_val, shadow_val, nxt_val;
  logic [3:0]    active_dp, shadow_dp, nxt_dp;
  logic          boundary, lz_dark, dark, lit;

  // Outputs are registered from the next-state view so they line up with the state they describe.
  always_comb begin
    boundary  = (phase == SHOW) && (cnt == SLOT_LAST) && (idx == 2'd3);
    nxt_cnt   = cnt + CW'(1);
    nxt_idx   = idx;
    nxt_phase = phase;
    if (phase == BLANK) begin
      if (cnt == BLANK_LAST) nxt_phase = SHOW;
    end else if (cnt == SLOT_LAST) begin
      nxt_cnt   = '0;
      nxt_idx   = idx + 2'd1;
      nxt_phase = START_PH;
    end
    nxt_val = (boundary && pending) ? shadow_val : active_val;
    nxt_dp  = (boundary && pending) ? shadow_dp  : active_dp;
    // A digit is a leading zero when it and every more significant nibble are zero.
    lz_dark = lz_blank && (nxt_idx != 2'd0) && ((nxt_val >> {nxt_idx, 2'b00}) == 16'h0000);
    dark    = !digit_en[nxt_idx] || lz_dark;
    lit     = (nxt_phase == SHOW) && !dark;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase      <= START_PH;
      idx        <= 2'd0;
      cnt        <= '0;
      active_val <= 16'h0000;
      active_dp  <= 4'h0;
      shadow_val <= 16'h0000;
      shadow_dp  <= 4'h0;
      pending    <= 1'b0;
      an         <= 4'hF;
      hex        <= 4'h0;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      phase      <= nxt_phase;
      idx        <= nxt_idx;
      cnt        <= nxt_cnt;
      active_val <= nxt_val;
      active_dp  <= nxt_dp;
      if (wr_en) begin
        shadow_val <= wr_data;
        shadow_dp  <= wr_dp;
      end
      // A write in the boundary cycle keeps pending set for the following frame.
      pending    <= wr_en || (pending && !boundary);
      an         <= lit ? ~(4'b0001 << nxt_idx) : 4'hF;
      dp_n       <= lit ? ~nxt_dp[nxt_idx] : 1'b1;
      hex        <= nxt_val[{nxt_idx, 2'b00} +: 4];
      frame_tick <= boundary;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - directed vector bench for seven_seg_scan_ctrl (CLK_DIV=8, BLANK_CYC=2)
module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = 16'h0000;
  logic [3:0]  wr_dp = 4'h0;
  logic [3:0]  digit_en = 4'hF;
  logic        lz_blank = 1'b0;
  logic [3:0]  hex;
  logic        dp_n;
  logic [3:0]  an;
  logic        frame_tick;
  logic        pending;

  seven_seg_scan_ctrl #(.CLK_DIV(8), .BLANK_CYC(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_dp(wr_dp),
    .digit_en(digit_en), .lz_blank(lz_blank), .hex(hex), .dp_n(dp_n), .an(an),
    .frame_tick(frame_tick), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst_first;
    int          cyc;
    bit          wr;
    logic [15:0] wd;
    logic [3:0]  wdp;
    logic [3:0]  den;
    bit          lz;
    logic [3:0]  an;
    logic [3:0]  hex;
    bit          dpn;
    bit          tick;
    bit          pend;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  function automatic vec_t mk(bit r, int c, bit w, logic [15:0] wd, logic [3:0] wdp,
                              logic [3:0] den, bit lz, logic [3:0] ea, logic [3:0] eh,
                              bit edp, bit et, bit ep);
    vec_t v;
    v.rst_first = r; v.cyc = c; v.wr = w; v.wd = wd; v.wdp = wdp; v.den = den; v.lz = lz;
    v.an = ea; v.hex = eh; v.dpn = edp; v.tick = et; v.pend = ep;
    return v;
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d: got %h required %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_out(logic [3:0] ea, logic [3:0] eh, bit edp, bit et, bit ep);
    chk("an", {12'h0, an}, {12'h0, ea});
    chk("hex", {12'h0, hex}, {12'h0, eh});
    chk("dp_n", {15'h0, dp_n}, {15'h0, edp});
    chk("frame_tick", {15'h0, frame_tick}, {15'h0, et});
    chk("pending", {15'h0, pending}, {15'h0, ep});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    cyc++;
    checks++;
    if ($countones(~an) > 1 || (an == 4'hF && dp_n !== 1'b1) ||
        (digit_en == 4'b1011 && an == 4'b1011)) begin
      errors++;
      $display("FAIL invariant cyc %0d: an=%b dp_n=%b digit_en=%b", cyc, an, dp_n, digit_en);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic run_to(int t);
    while (cyc < t) step();
  endtask

  task automatic write(logic [15:0] d, logic [3:0] p);
    wr_data = d;
    wr_dp = p;
    wr_en = 1'b1;
  endtask

  initial begin
    // Reset scan plus write/swap of 1A3F with DP on digit 2.
    vecs.push_back(mk(1,  0, 0, 0, 0, 4'hF, 0, 4'b1111, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0,  1, 0, 0, 0, 4'hF, 0, 4'b1111, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0,  2, 0, 0, 0, 4'hF, 0, 4'b1110, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0,  5, 1, 16'h1A3F, 4'b0100, 4'hF, 0, 4'b1110, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0,  6, 0, 0, 0, 4'hF, 0, 4'b1110, 4'h0, 1, 0, 1));
    vecs.push_back(mk(0,  8, 0, 0, 0, 4'hF, 0, 4'b1111, 4'h0, 1, 0, 1));
    vecs.push_back(mk(0, 10, 0, 0, 0, 4'hF, 0, 4'b1101, 4'h0, 1, 0, 1));
    vecs.push_back(mk(0, 18, 0, 0, 0, 4'hF, 0, 4'b1011, 4'h0, 1, 0, 1));
    vecs.push_back(mk(0, 26, 0, 0, 0, 4'hF, 0, 4'b0111, 4'h0, 1, 0, 1));
    vecs.push_back(mk(0, 31, 0, 0, 0, 4'hF, 0, 4'b0111, 4'h0, 1, 0, 1));
    vecs.push_back(mk(0, 32, 0, 0, 0, 4'hF, 0, 4'b1111, 4'hF, 1, 1, 0));
    vecs.push_back(mk(0, 33, 0, 0, 0, 4'hF, 0, 4'b1111, 4'hF, 1, 0, 0));
    vecs.push_back(mk(0, 34, 0, 0, 0, 4'hF, 0, 4'b1110, 4'hF, 1, 0, 0));
    vecs.push_back(mk(0, 42, 0, 0, 0, 4'hF, 0, 4'b1101, 4'h3, 1, 0, 0));
    vecs.push_back(mk(0, 48, 0, 0, 0, 4'hF, 0, 4'b1111, 4'hA, 1, 0, 0));
    vecs.push_back(mk(0, 50, 0, 0, 0, 4'hF, 0, 4'b1011, 4'hA, 0, 0, 0));
    vecs.push_back(mk(0, 56, 0, 0, 0, 4'hF, 0, 4'b1111, 4'h1, 1, 0, 0));
    vecs.push_back(mk(0, 58, 0, 0, 0, 4'hF, 0, 4'b0111, 4'h1, 1, 0, 0));
    vecs.push_back(mk(0, 64, 0, 0, 0, 4'hF, 0, 4'b1111, 4'hF, 1, 1, 0));
    // Leading-zero blanking with 0050, then 0000, then lz_blank dropped live.
    vecs.push_back(mk(1,  1, 1, 16'h0050, 4'h0, 4'hF, 1, 4'b1111, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0, 34, 0, 0, 0, 4'hF, 1, 4'b1110, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0, 42, 0, 0, 0, 4'hF, 1, 4'b1101, 4'h5, 1, 0, 0));
    vecs.push_back(mk(0, 50, 0, 0, 0, 4'hF, 1, 4'b1111, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0, 58, 0, 0, 0, 4'hF, 1, 4'b1111, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0, 60, 1, 16'h0000, 4'h0, 4'hF, 1, 4'b1111, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0, 61, 0, 0, 0, 4'hF, 1, 4'b1111, 4'h0, 1, 0, 1));
    vecs.push_back(mk(0, 66, 0, 0, 0, 4'hF, 1, 4'b1110, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0, 74, 0, 0, 0, 4'hF, 1, 4'b1111, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0, 75, 0, 0, 0, 4'hF, 0, 4'b1111, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0, 76, 0, 0, 0, 4'hF, 0, 4'b1101, 4'h0, 1, 0, 0));
    // digit_en = 1011 with value 4321 and all DPs set.
    vecs.push_back(mk(1,  0, 0, 0, 0, 4'b1011, 0, 4'b1111, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0,  3, 1, 16'h4321, 4'hF, 4'b1011, 0, 4'b1110, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0, 10, 0, 0, 0, 4'b1011, 0, 4'b1101, 4'h0, 1, 0, 1));
    vecs.push_back(mk(0, 18, 0, 0, 0, 4'b1011, 0, 4'b1111, 4'h0, 1, 0, 1));
    vecs.push_back(mk(0, 26, 0, 0, 0, 4'b1011, 0, 4'b0111, 4'h0, 1, 0, 1));
    vecs.push_back(mk(0, 42, 0, 0, 0, 4'b1011, 0, 4'b1101, 4'h2, 0, 0, 0));
    vecs.push_back(mk(0, 50, 0, 0, 0, 4'b1011, 0, 4'b1111, 4'h3, 1, 0, 0));

    foreach (vecs[i]) begin
      if (vecs[i].rst_first) do_reset();
      run_to(vecs[i].cyc);
      chk_out(vecs[i].an, vecs[i].hex, vecs[i].dpn, vecs[i].tick, vecs[i].pend);
      digit_en = vecs[i].den;
      lz_blank = vecs[i].lz;
      if (vecs[i].wr) write(vecs[i].wd, vecs[i].wdp);
    end

    // Reset in the SHOW phase of digit 3 with a write pending.
    run_to(57);
    write(16'h9999, 4'h0);
    run_to(58);
    chk_out(4'b0111, 4'h4, 0, 0, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    cyc = 0;
    chk_out(4'b1111, 4'h0, 1, 0, 0);
    run_to(2);
    chk_out(4'b1110, 4'h0, 1, 0, 0);

    // Write landing exactly on the frame boundary cycle.
    do_reset();
    digit_en = 4'hF;
    lz_blank = 1'b0;
    run_to(3);
    write(16'h1111, 4'h0);
    run_to(31);
    chk_out(4'b0111, 4'h0, 1, 0, 1);
    write(16'h2222, 4'h0);
    run_to(32);
    chk_out(4'b1111, 4'h1, 1, 1, 1);
    run_to(42);
    chk_out(4'b1101, 4'h1, 1, 0, 1);
    run_to(63);
    chk_out(4'b0111, 4'h1, 1, 0, 1);
    run_to(64);
    chk_out(4'b1111, 4'h2, 1, 1, 0);
    run_to(66);
    chk_out(4'b1110, 4'h2, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Time-multiplexing scan controller for a 4-digit common-anode seven-segment display. It holds a double-buffered 16-bit display value and per-digit decimal points, and steps through the digits one at a time. For each digit it presents the digit's 4-bit nibble and active-low decimal point to the downstream hex-to-seven-segment decoder, and drives the matching active-low digit anode. A dead-time interval between digits suppresses ghosting. New values are swapped in only at frame boundaries, so the display never tears.

## Interface

Parameters:
- CLK_DIV, 50000: clock cycles per digit slot. Must be ≥ 2.
- BLANK_CYC, 500: dead-time cycles at the start of each slot, with all anodes off. Must satisfy 0 ≤ BLANK_CYC < CLK_DIV.

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  one-cycle write strobe into the shadow buffer
- wr_data  in  16  display value; nibble i goes to digit i (digit 0 is least significant)
- wr_dp  in  4  decimal-point enables; bit i = 1 lights the DP of digit i
- digit_en  in  4  live per-digit enable; 0 forces that digit dark
- lz_blank  in  1  live leading-zero blanking enable
- hex  out  4  nibble for the decoder
- dp_n  out  1  active-low decimal point for the decoder
- an  out  4  active-low digit anodes; at most one bit low at any time
- frame_tick  out  1  one-cycle pulse when a new frame starts
- pending  out  1  shadow buffer holds data not yet displayed

## Operation

Registers:
- active value (16 bits) and active DP (4 bits)
- shadow value (16 bits) and shadow DP (4 bits)
- digit index idx, 2 bits
- slot counter cnt, $clog2(CLK_DIV) bits
- phase: BLANK or SHOW

Write path:
- wr_en = 1 loads the shadow value and shadow DP, and sets pending.
- Back-to-back writes overwrite the shadow; the last write wins.

Phase state machine:
- BLANK: an = 4'b1111 and dp_n = 1. Moves to SHOW when cnt reaches BLANK_CYC-1. If BLANK_CYC = 0, BLANK is skipped entirely.
- SHOW: drives an[idx] = 0 unless the digit is dark, and dp_n = ~activeDP[idx]. At cnt = CLK_DIV-1: cnt returns to 0, idx increments (wrapping 3 → 0), and phase returns to BLANK.

Nibble output:
- hex = active[4*idx+3 : 4*idx] in both phases, so the decoder settles during dead time.

Dark-digit rule for digit i:
- The digit is dark if digit_en[i] = 0.
- It is also dark if lz_blank = 1, i > 0, and every nibble from i through 3 is zero.
- Digit 0 is never dark because of leading-zero blanking.
- A dark digit still uses its full slot: an = 1111 and dp_n = 1, but hex is still driven.

Frame boundary (end of the digit-3 slot, cnt = CLK_DIV-1):
- If pending = 1, copy shadow to active and clear pending.
- Pulse frame_tick in the next cycle, which is the first cycle of the digit-0 slot.
- If wr_en arrives in the boundary cycle itself: the copy uses the old shadow, the new data lands in the shadow, and pending stays 1 until the next boundary.

Reset:
- Asserting rst at any point aborts the current slot.
- Reset values: an = 1111, hex = 0, dp_n = 1, frame_tick = 0, pending = 0, active = 0, shadow = 0, idx = 0, cnt = 0, phase = BLANK (or SHOW if BLANK_CYC = 0).

## Timing

- All outputs are registered. Each output changes in the same cycle as the state it reflects; there is no additional pipeline delay.
- Slots: slot k occupies cycles k·CLK_DIV through k·CLK_DIV + CLK_DIV-1 after reset release. The first BLANK_CYC cycles of each slot have all anodes off; the remaining CLK_DIV-BLANK_CYC cycles have the anode on.
- Frame period is 4·CLK_DIV cycles. frame_tick is high in cycles 4n·CLK_DIV for n ≥ 1 only; it does not pulse after reset.
- Write latency: data written in cycle t becomes visible at the first frame boundary strictly after t. It reaches the display at most 4·CLK_DIV + 1 cycles later.
- digit_en and lz_blank are sampled every cycle, so a change takes effect within one cycle.
- Invariant: an is never 0 in more than one bit, including across reset and slot edges.

## Test plan

All scenarios use CLK_DIV = 8 and BLANK_CYC = 2.

- Reset/scan:
  - Stimulus: release rst with all digit_en = 1111.
  - Required: an runs 1111 ×2, 1110 ×6, 1111 ×2, 1101 ×6, … up to 0111, then repeats. hex = 0 throughout. frame_tick first pulses at cycle 32.
- Write/swap:
  - Stimulus: wr_en with 16'h1A3F and wr_dp = 4'b0100 at cycle 5.
  - Required: pending = 1 from cycle 6 until the boundary. From cycle 32: hex = F, 3, A, 1 in slots 0–3. dp_n = 0 only during the SHOW phase of digit 2. pending = 0 from cycle 32.
- Boundary collision:
  - Stimulus: write 16'h1111, then write 16'h2222 exactly at cycle 31.
  - Required: frame 1 shows 1111 and pending stays 1. Frame 2 (from cycle 64) shows 2222 and pending clears.
- Leading-zero blanking:
  - Stimulus: value 16'h0050 with lz_blank = 1.
  - Required: digits 2 and 3 stay dark; digits 0 and 1 light. With value 16'h0000, only digit 0 lights.
- digit_en and reset mid-slot:
  - Stimulus: set digit_en = 4'b1011. Later, assert rst during a SHOW phase.
  - Required: an never shows 1011. The cycle after rst, an = 1111, pending = 0, and the scan restarts at digit 0.
- Invariant check (whole run):
  - Required: in every cycle, an has at most one 0 bit, and dp_n = 1 whenever an = 1111.
